// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential multiplier family.
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } mul_state_t;

    // Widest operand the shared helpers handle; callers cast in and out.
    localparam int MAX_W = 32;

    // Magnitude of a w-bit two's-complement value held in the low bits of v.
    // The most-negative value maps to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                               input int unsigned      w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] sign_mask;
        mask      = {MAX_W{1'b1}} >> (MAX_W - w);
        sign_mask = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
        if ((v & sign_mask) != '0)
            return (~v + 1'b1) & mask;
        else
            return v & mask;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: conditionally adds the multiplicand, aligned to bit cnt, into acc.
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mplier_bit,
    input  logic [CW-1:0]      cnt,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] partial;

    always_comb begin
        partial  = {{WIDTH{1'b0}}, mcand} << cnt;
        acc_next = mplier_bit ? (acc + partial) : acc;
    end

endmodule

// File: rtl/mul_nbits_seq.sv
// Sequential shift-add multiplier with valid/ready handshakes, one partial product
// per clock, unsigned or two's-complement operands selected per operation.
module mul_nbits_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    mul_state_t        state, state_next;
    logic [WIDTH-1:0]  mcand, mplier;
    logic              neg;
    logic [PW-1:0]     acc, acc_next;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              accept, last;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign a_mag  = WIDTH'(abs_w(MAX_W'(a), WIDTH));
    assign b_mag  = WIDTH'(abs_w(MAX_W'(b), WIDTH));

    mul_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier_bit (mplier[0]),
        .cnt        (cnt),
        .acc_next   (acc_next)
    );

    // NOTE: state and data registers use non-blocking assignments so every
    // register samples pre-edge values, matching the hardware it describes.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // NOTE: the default first assignment keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (accept)    state_next = S_CALC;
            S_CALC:  if (last)      state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !rst;
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    // NOTE: the datapath is cleared on reset too, so p reads 0 after reset and
    // a discarded operation leaves no residue in acc or cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        mcand  <= signed_mode ? a_mag : a;
                        mplier <= signed_mode ? b_mag : b;
                        neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Sign fix-up on the final partial product; -0 is still 0.
                    if (last)
                        p <= neg ? -acc_next : acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule
